fxp_acc_dump: RTL and testbench
===============================

// Module: fxp_acc_dump
// PURPOSE
//   Accumulate-and-dump stage directly downstream of the fixed-point subtractor.
//   Sums NUM_TERMS signed differences (filter error terms) in a widened accumulator.
//   Presents the sum, clamped or wrapped to BIT_WIDTH, through a one-entry valid/ready output register.
// PARAMETERS
//   BIT_WIDTH  16  width of signed input samples and output result (same Q format, no shift)
//   NUM_TERMS  4   samples per dump; legal range 2..256
//   ACC_WIDTH  BIT_WIDTH+$clog2(NUM_TERMS)  internal accumulator width (derived; do not override)
// PORTS
//   CLK        in   1          clock, rising edge
//   RST        in   1          asynchronous, active-high reset
//   clr        in   1          synchronous flush of partial sum and pending output
//   in_valid   in   1          a is valid this cycle
//   in_ready   out  1          stage accepts a this cycle
//   a          in   BIT_WIDTH  signed difference sample from fxp_sub
//   out_valid  out  1          y/ovf valid
//   out_ready  in   1          consumer accepts y this cycle
//   y          out  BIT_WIDTH  signed dumped sum
//   ovf        out  1          sum exceeded BIT_WIDTH range (qualified by out_valid)
// BEHAVIOUR
//   Reset: state=ACCUM, acc=0, cnt=0, y=0, ovf=0, out_valid=0; in_ready=1 on the first cycle after RST falls.
//   States:
//   - ACCUM: in_ready=1, out_valid=0. On in_valid: acc<=acc+sext(a), cnt<=cnt+1.
//   - Completing sample: on the sample with cnt==NUM_TERMS-1, register y/ovf from acc+sext(a) and go to HOLD.
//     Latency: out_valid is high the cycle after the last sample is accepted.
//   - HOLD: in_ready=0, out_valid=1. y/ovf stay stable until out_ready.
//     On out_ready: acc<=0, cnt<=0, go to ACCUM. One bubble cycle per dump (no same-cycle refill).
//   Arithmetic: two's complement, ACC_WIDTH bits, which never overflows internally.
//     Output conversion: see CONFIGURATION.
//   clr:
//   - Highest priority. Next cycle: acc=0, cnt=0, state=ACCUM, out_valid=0.
//   - Any concurrent input sample is dropped. A HOLD result is discarded even if out_ready is high.
//   in_valid while in_ready=0: ignored; the producer must hold a.
//   cnt wraps only via dump or clr; it never exceeds NUM_TERMS-1.
//   RST mid-operation: all state returns to reset values immediately (async); the partial sum is lost.
//   Outputs registered except in_ready, which is decoded from state.
// CONFIGURATION
//   FXP_ACC_SAT_EN defined:
//   - y = clamp(sum, -2^(BIT_WIDTH-1), 2^(BIT_WIDTH-1)-1).
//   - ovf=1 when clamping occurred.
//   FXP_ACC_SAT_EN undefined:
//   - y = sum[BIT_WIDTH-1:0] (wrap).
//   - ovf tied 0. Saturation logic is not synthesised.
// TESTING  (BIT_WIDTH=16, NUM_TERMS=4)
//   1. a=100,-30,5,25 back-to-back, out_ready=1 -> out_valid 1 cycle after 4th sample.
//      y=100, ovf=0. in_ready=0 that cycle and 1 the next.
//   2. a=20000 x4 -> SAT_EN: y=32767, ovf=1. No macro: y=14464, ovf=0.
//      a=-20000 x4 -> SAT_EN: y=-32768, ovf=1. No macro: y=-14464.
//   3. Completed dump with out_ready=0 for 5 cycles -> y stable, out_valid=1, in_ready=0 throughout.
//      Accepted on cycle 6; next sample accepted cycle 7.
//   4. 2 samples (7,8), then clr together with in_valid (a=1000), then a=1,2,3,4 -> y=10.
//      The partial sum and the clr-cycle sample are discarded.
//   5. RST pulsed mid-HOLD and mid-ACCUM (asynchronously, between edges) -> out_valid=0 and y=0 immediately.
//      The next dump sums only post-reset samples.
//   6. in_valid toggling randomly (gaps) with a=-1 each -> y=-4 per dump. Exactly 4 accepted samples per dump.

Source files
------------

// File: rtl/fxp_acc_dump.sv
// Sums NUM_TERMS signed samples, then holds the result for one valid/ready handshake (one cycle after the last sample; input stalls while held).
// FXP_ACC_SAT_EN selects a clamped result with ovf; when undefined the result wraps and ovf is tied low.
`timescale 1ns/1ps
module fxp_acc_dump #(
  parameter int BIT_WIDTH = 16,
  parameter int NUM_TERMS = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] a,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] y,
  output logic                 ovf
);

  localparam int ACC_WIDTH = BIT_WIDTH + $clog2(NUM_TERMS);
  localparam int CNT_W     = $clog2(NUM_TERMS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);

  typedef enum logic {
    S_ACCUM,
    S_HOLD
  } state_t;

  state_t                 r_state;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_out_valid;
  logic [BIT_WIDTH-1:0]   r_y;

  logic [ACC_WIDTH-1:0]   w_sum;
  logic                   w_last;
  logic [BIT_WIDTH-1:0]   w_y_next;

  assign w_sum  = r_acc + {{(ACC_WIDTH-BIT_WIDTH){a[BIT_WIDTH-1]}}, a};
  assign w_last = (r_cnt == LAST_CNT);

`ifdef FXP_ACC_SAT_EN
  localparam logic [BIT_WIDTH-1:0] Y_MAX = {1'b0, {(BIT_WIDTH-1){1'b1}}};
  localparam logic [BIT_WIDTH-1:0] Y_MIN = {1'b1, {(BIT_WIDTH-1){1'b0}}};

  logic r_ovf;
  logic w_in_range;
  logic w_ovf_next;

  // The sum fits when every bit from the output sign bit upward agrees.
  assign w_in_range = (&w_sum[ACC_WIDTH-1:BIT_WIDTH-1]) | ~(|w_sum[ACC_WIDTH-1:BIT_WIDTH-1]);
  assign w_ovf_next = ~w_in_range;
  assign w_y_next   = w_in_range ? w_sum[BIT_WIDTH-1:0] :
                      (w_sum[ACC_WIDTH-1] ? Y_MIN : Y_MAX);
  assign ovf        = r_ovf;
`else
  assign w_y_next = w_sum[BIT_WIDTH-1:0];
  assign ovf      = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_y         <= '0;
`ifdef FXP_ACC_SAT_EN
      r_ovf       <= 1'b0;
`endif
    end else if (clr) begin
      r_state     <= S_ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_ACCUM: begin
          if (in_valid) begin
            if (w_last) begin
              r_y         <= w_y_next;
`ifdef FXP_ACC_SAT_EN
              r_ovf       <= w_ovf_next;
`endif
              r_out_valid <= 1'b1;
              r_state     <= S_HOLD;
            end else begin
              r_acc <= w_sum;
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_HOLD: begin
          // No same-cycle refill: the freed slot accepts input from the next cycle on.
          if (out_ready) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_state     <= S_ACCUM;
          end
        end
        default: r_state <= S_ACCUM;
      endcase
    end
  end

  assign in_ready  = (r_state == S_ACCUM);
  assign out_valid = r_out_valid;
  assign y         = r_y;

endmodule

// File: tb/tb_fxp_acc_dump.sv
// Directed bench for fxp_acc_dump (BIT_WIDTH=16, NUM_TERMS=4) with an integer reference model checked every cycle.
`timescale 1ns/1ps
module tb_fxp_acc_dump;
  localparam int BW   = 16;
  localparam int NT   = 4;
  localparam int MAXV = 32767;
  localparam int MINV = -32768;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [BW-1:0] a = '0;
  logic          in_ready;
  logic          out_valid;
  logic [BW-1:0] y;
  logic          ovf;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 CLK = ~CLK;

  fxp_acc_dump #(.BIT_WIDTH(BW), .NUM_TERMS(NT)) dut (
    .CLK(CLK), .RST(RST), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .a(a),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .ovf(ovf)
  );

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference conversion of an exact integer sum to the 16-bit output.
  function automatic int conv_y(int s);
`ifdef FXP_ACC_SAT_EN
    if (s > MAXV) return MAXV;
    if (s < MINV) return MINV;
    return s;
`else
    int w;
    w = s & 32'h0000FFFF;
    if (w > MAXV) w = w - 65536;
    return w;
`endif
  endfunction

  function automatic bit conv_ovf(int s);
`ifdef FXP_ACC_SAT_EN
    return (s > MAXV) || (s < MINV);
`else
    return (s != s);
`endif
  endfunction

  // Model: exact running sum, sample count and a pending-result flag.
  int m_sum = 0;
  int m_n   = 0;
  int m_y   = 0;
  bit m_ovf = 1'b0;
  bit m_valid = 1'b0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_sum <= 0; m_n <= 0; m_valid <= 1'b0;
    end else if (clr) begin
      m_sum <= 0; m_n <= 0; m_valid <= 1'b0;
    end else if (m_valid) begin
      if (out_ready) begin
        m_sum <= 0; m_n <= 0; m_valid <= 1'b0;
      end
    end else if (in_valid) begin
      m_sum <= m_sum + int'($signed(a));
      m_n   <= m_n + 1;
      if (m_n == NT - 1) begin
        m_y     <= conv_y(m_sum + int'($signed(a)));
        m_ovf   <= conv_ovf(m_sum + int'($signed(a)));
        m_valid <= 1'b1;
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en && !RST) begin
      chk("cyc_in_ready", int'(in_ready), int'(!m_valid));
      chk("cyc_out_valid", int'(out_valid), int'(m_valid));
      if (m_valid) begin
        chk("cyc_y", int'($signed(y)), m_y);
        chk("cyc_ovf", int'(ovf), int'(m_ovf));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Presents one sample and returns just after the edge that accepted it.
  task automatic send(input int v);
    bit ok;
    ok = 1'b0;
    a = BW'(v);
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_dump(string name, int ey, int eovf);
    @(negedge CLK);
    chk({name, "_valid"}, int'(out_valid), 1);
    chk({name, "_y"}, int'($signed(y)), ey);
    chk({name, "_ovf"}, int'(ovf), eovf);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dumps;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_y", int'($signed(y)), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(negedge CLK);
    RST = 1'b0;
    chk_en = 1'b1;
    tick();
    chk("post_rst_in_ready", int'(in_ready), 1);

    // 1: mixed-sign back-to-back samples, consumer always ready
    out_ready = 1'b1;
    send(100); send(-30); send(5); send(25);
    @(negedge CLK);
    chk("t1_out_valid", int'(out_valid), 1);
    chk("t1_in_ready", int'(in_ready), 0);
    chk("t1_y", int'($signed(y)), 100);
    tick();
    @(negedge CLK);
    chk("t1_out_valid_after", int'(out_valid), 0);
    chk("t1_in_ready_after", int'(in_ready), 1);
    tick();

    // 2: large positive and negative sums
    send(20000); send(20000); send(20000); send(20000);
`ifdef FXP_ACC_SAT_EN
    expect_dump("t2_pos", 32767, 1);
`else
    expect_dump("t2_pos", 14464, 0);
`endif
    send(-20000); send(-20000); send(-20000); send(-20000);
`ifdef FXP_ACC_SAT_EN
    expect_dump("t2_neg", -32768, 1);
`else
    expect_dump("t2_neg", -14464, 0);
`endif

    // 3: result held five cycles while a new sample waits
    out_ready = 1'b0;
    send(1); send(2); send(3); send(4);
    a = BW'(9);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      chk("t3_hold_valid", int'(out_valid), 1);
      chk("t3_hold_in_ready", int'(in_ready), 0);
      chk("t3_hold_y", int'($signed(y)), 10);
      tick();
    end
    out_ready = 1'b1;
    @(negedge CLK);
    chk("t3_c6_valid", int'(out_valid), 1);
    tick();
    @(negedge CLK);
    chk("t3_c7_in_ready", int'(in_ready), 1);
    chk("t3_c7_out_valid", int'(out_valid), 0);
    tick();
    in_valid = 1'b0;
    send(1); send(1); send(1);
    expect_dump("t3_next", 12, 0);

    // 4: clr drops the partial sum and its own concurrent sample
    send(7); send(8);
    clr = 1'b1;
    a = BW'(1000);
    in_valid = 1'b1;
    tick();
    clr = 1'b0;
    in_valid = 1'b0;
    send(1); send(2); send(3); send(4);
    expect_dump("t4", 10, 0);

    // 5: asynchronous reset between edges, in HOLD and in ACCUM
    out_ready = 1'b0;
    send(5); send(5); send(5); send(5);
    @(negedge CLK);
    chk("t5_hold_valid", int'(out_valid), 1);
    #2 RST = 1'b1;
    #1;
    chk("t5_rst_hold_valid", int'(out_valid), 0);
    chk("t5_rst_hold_y", int'($signed(y)), 0);
    chk("t5_rst_hold_in_ready", int'(in_ready), 1);
    #1 RST = 1'b0;
    tick();
    send(100); send(100);
    #1 RST = 1'b1;
    #1;
    chk("t5_rst_acc_valid", int'(out_valid), 0);
    chk("t5_rst_acc_y", int'($signed(y)), 0);
    #1 RST = 1'b0;
    tick();
    out_ready = 1'b1;
    send(1); send(2); send(3); send(4);
    expect_dump("t5_after", 10, 0);

    // 6: gappy input of -1 with an intermittently ready consumer
    dumps = 0;
    for (int i = 0; i < 80; i++) begin
      in_valid = ($urandom_range(0, 1) == 1);
      a = '1;
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge CLK);
      if (out_valid) begin
        chk("t6_y", int'($signed(y)), -4);
        if (out_ready) dumps++;
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("t6_dumps_seen", int'(dumps >= 3), 1);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
